// File: rtl/midi_router_pkg.sv
// Shared definitions for the MIDI router configuration path: state encodings and defaults.
package midi_router_pkg;

  localparam int unsigned ROUTE_BITS   = 16;
  localparam int unsigned ROUTE_CLKDIV = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOW   = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOW   = ST_LOW,
    S_HIGH  = ST_HIGH,
    S_LATCH = ST_LATCH,
    S_DONE  = ST_DONE
  } route_state_e;

endpackage

// File: rtl/route_cfg_ctrl_if.sv
// Host handshake plus serial chain lines of the routing configuration controller.
interface route_cfg_ctrl_if #(
  parameter int unsigned NBITS = midi_router_pkg::ROUTE_BITS
);
  logic             cfg_valid;
  logic [NBITS-1:0] cfg_data;
  logic             cfg_ready;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             spi_clk;
  logic             spi_dout;
  logic             spi_latch;
  logic             spi_din;

  modport master (
    output cfg_valid, cfg_data, spi_din,
    input  cfg_ready, busy, done, cfg_err, spi_clk, spi_dout, spi_latch
  );

  modport slave (
    input  cfg_valid, cfg_data, spi_din,
    output cfg_ready, busy, done, cfg_err, spi_clk, spi_dout, spi_latch
  );
endinterface

// File: rtl/route_phase_timer.sv
// Counts CLKDIV clk cycles per FSM state; tick_c marks the last cycle of the phase.
module route_phase_timer #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic restart,
  output logic tick_c
);
  localparam int unsigned PW = $clog2(CLKDIV + 1);
  localparam logic [PW-1:0] TERM = PW'(CLKDIV - 1);

  logic [PW-1:0] cnt_q;

  // Saturates at the terminal count so an idle FSM never wraps the counter.
  always_ff @(posedge clk) begin
    if (!nreset || restart) begin
      cnt_q <= '0;
    end else if (cnt_q != TERM) begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

  assign tick_c = (cnt_q == TERM);
endmodule

// File: rtl/route_cfg_ctrl.sv
// Loads a routing word into the shift-register chain MSB-first, then strobes the latch.
// Chain readback checking is compiled in with ROUTE_CFG_READBACK_EN.
module route_cfg_ctrl
  import midi_router_pkg::*;
#(
  parameter int unsigned NBITS  = ROUTE_BITS,
  parameter int unsigned CLKDIV = ROUTE_CLKDIV
) (
  input  logic            clk,
  input  logic            nreset,
  route_cfg_ctrl_if.slave bus
);
  localparam int unsigned BW = $clog2(NBITS);

  route_state_e     state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             tick_c, restart_c, accept_c;

  logic cfg_ready_q, busy_q, done_q, spi_clk_q, spi_dout_q, spi_latch_q, cfg_err_q;
  logic cfg_ready_d, busy_d, done_d, spi_clk_d, spi_dout_d, spi_latch_d;

  assign accept_c  = (state_q == S_IDLE) && bus.cfg_valid;
  assign restart_c = (state_d != state_q);

  route_phase_timer #(.CLKDIV(CLKDIV)) u_phase_timer (
    .clk     (clk),
    .nreset  (nreset),
    .restart (restart_c),
    .tick_c  (tick_c)
  );

  // Next state; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    cfg_ready_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    spi_clk_d   = 1'b0;
    spi_latch_d = 1'b0;
    spi_dout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_LOW;
          shift_d = bus.cfg_data;
          bit_d   = BW'(NBITS - 1);
        end
      end
      S_LOW: begin
        if (tick_c) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (tick_c) begin
          shift_d = {shift_q[NBITS-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = S_LOW;
          end
        end
      end
      S_LATCH: begin
        if (tick_c) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    spi_clk_d   = (state_d == S_HIGH);
    spi_latch_d = (state_d == S_LATCH);
    // Data only moves on the falling serial-clock edge (HIGH->LOW) or at transfer start.
    spi_dout_d  = ((state_d == S_LOW) || (state_d == S_HIGH)) ? shift_d[NBITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spi_clk_q   <= 1'b0;
      spi_dout_q  <= 1'b0;
      spi_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      spi_clk_q   <= spi_clk_d;
      spi_dout_q  <= spi_dout_d;
      spi_latch_q <= spi_latch_d;
    end
  end

`ifdef ROUTE_CFG_READBACK_EN
  logic [NBITS-1:0] cap_q, shadow_q, word_q;
  logic             latch_entry_c;

  assign latch_entry_c = (state_q == S_HIGH) && (state_d == S_LATCH);

  // The chain shifts out its previous contents while the new word shifts in.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cap_q     <= '0;
      shadow_q  <= '0;
      word_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if ((state_q == S_LOW) && tick_c) cap_q <= {cap_q[NBITS-2:0], bus.spi_din};
      if (accept_c) word_q <= bus.cfg_data;
      if (state_q == S_DONE) shadow_q <= word_q;
      if (accept_c) begin
        cfg_err_q <= 1'b0;
      end else if (latch_entry_c && (cap_q != shadow_q)) begin
        cfg_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_spi_din;
  assign unused_spi_din = bus.spi_din;
  assign cfg_err_q      = 1'b0;
`endif

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.spi_clk   = spi_clk_q;
  assign bus.spi_dout  = spi_dout_q;
  assign bus.spi_latch = spi_latch_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_route_cfg_ctrl.sv
// Bench for route_cfg_ctrl: two controllers (CLKDIV 2 and 1) driving behavioural 8-bit chains.
module tb_route_cfg_ctrl;
  localparam int unsigned NB    = 8;
  localparam int unsigned LAT_A = 2 * 2 * NB + 2;
  localparam int unsigned LAT_B = 2 * 1 * NB + 1;

  typedef struct {
    logic [NB-1:0] word;
    int unsigned   due;
    logic          err;
  } exp_t;

  logic clk;
  logic nreset;
  logic corrupt;
  int unsigned cyc;
  int total;
  int bad;

  route_cfg_ctrl_if #(.NBITS(NB)) bus_a ();
  route_cfg_ctrl_if #(.NBITS(NB)) bus_b ();

  route_cfg_ctrl #(.NBITS(NB), .CLKDIV(2)) dut_a (.clk(clk), .nreset(nreset), .bus(bus_a));
  route_cfg_ctrl #(.NBITS(NB), .CLKDIV(1)) dut_b (.clk(clk), .nreset(nreset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain models: shift on rising serial clock, output stage copies on latch strobe.
  logic [NB-1:0] chain_a, regout_a, chain_b, regout_b;
  always @(posedge bus_a.spi_clk or negedge nreset)
    if (!nreset) chain_a <= '0; else chain_a <= {chain_a[NB-2:0], bus_a.spi_dout};
  always @(posedge bus_a.spi_latch) regout_a <= chain_a;
  always @(posedge bus_b.spi_clk or negedge nreset)
    if (!nreset) chain_b <= '0; else chain_b <= {chain_b[NB-2:0], bus_b.spi_dout};
  always @(posedge bus_b.spi_latch) regout_b <= chain_b;

  int rises_a, latch_cnt_a, done_cnt_a;
  assign bus_a.spi_din = chain_a[NB-1] ^ (corrupt && (rises_a == 2));
  assign bus_b.spi_din = chain_b[NB-1];

  exp_t sb[$];
  exp_t e;
  logic [NB-1:0] bits_a;
  logic prev_clk_a, prev_rdy_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [NB-1:0] w, input logic err);
    int n = 0;
    while (!bus_a.cfg_ready && n < 500) begin
      step();
      n++;
    end
    chk("a_ready_wait", bus_a.cfg_ready, 1);
    bus_a.cfg_valid = 1'b1;
    bus_a.cfg_data  = w;
    sb.push_back('{w, cyc + 1 + LAT_A, err});
    step();
    bus_a.cfg_valid = 1'b0;
    chk("a_accept_ready_low", bus_a.cfg_ready, 0);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((sb.size() != 0 || !bus_a.cfg_ready) && n < 2000) begin
      step();
      n++;
    end
    chk("a_idle_timeout", sb.size(), 0);
  endtask

  // Scoreboard side: collect serial bits and latch width, pop expectation on done.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (prev_rdy_a && !bus_a.cfg_ready) begin
        rises_a     = 0;
        latch_cnt_a = 0;
        bits_a      = '0;
      end
      if (bus_a.spi_clk && !prev_clk_a) begin
        rises_a++;
        bits_a = {bits_a[NB-2:0], bus_a.spi_dout};
      end
      if (bus_a.spi_latch) begin
        latch_cnt_a++;
        chk("a_latch_owner", sb.size() != 0, 1);
      end
      chk("a_clk_latch_excl", bus_a.spi_clk & bus_a.spi_latch, 0);
      chk("a_busy_vs_ready", bus_a.busy, !bus_a.cfg_ready);
      if (bus_a.done) begin
        done_cnt_a++;
        chk("a_done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("a_latency", cyc, e.due);
          chk("a_regout", regout_a, e.word);
          chk("a_dout_seq", bits_a, e.word);
          chk("a_rises", rises_a, NB);
          chk("a_latch_len", latch_cnt_a, 2);
          chk("a_cfg_err", bus_a.cfg_err, e.err);
        end
      end
      prev_clk_a = bus_a.spi_clk;
      prev_rdy_a = bus_a.cfg_ready;
    end
  end

  initial begin
    int n;
    int hi;
    int unsigned a1, d1, a2, d2, dc;
    nreset          = 1'b0;
    corrupt         = 1'b0;
    bus_a.cfg_valid = 1'b0;
    bus_a.cfg_data  = '0;
    bus_b.cfg_valid = 1'b0;
    bus_b.cfg_data  = '0;
    repeat (3) step();

    chk("rst_ready", bus_a.cfg_ready, 1);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_spi_clk", bus_a.spi_clk, 0);
    chk("rst_spi_dout", bus_a.spi_dout, 0);
    chk("rst_spi_latch", bus_a.spi_latch, 0);
    chk("rst_cfg_err", bus_a.cfg_err, 0);
    nreset = 1'b1;
    step();

    // Basic transfer
    send_a(8'hA5, 1'b0);
    wait_idle_a();
    chk("a5_regout", regout_a, 8'hA5);

    // cfg_valid pulsed while busy must be ignored
    dc = done_cnt_a;
    send_a(8'h96, 1'b0);
    repeat (5) step();
    bus_a.cfg_valid = 1'b1;
    bus_a.cfg_data  = 8'h3C;
    repeat (3) step();
    chk("ign_ready_low", bus_a.cfg_ready, 0);
    bus_a.cfg_valid = 1'b0;
    wait_idle_a();
    repeat (40) step();
    chk("ign_done_cnt", done_cnt_a, dc + 1);
    chk("ign_regout", regout_a, 8'h96);

    // Reset during the 4th HIGH phase aborts without latching
    send_a(8'hC3, 1'b0);
    n = 0;
    while (!(rises_a == 4 && bus_a.spi_clk) && n < 200) begin
      step();
      n++;
    end
    chk("abort_reached_high4", rises_a, 4);
    dc = done_cnt_a;
    nreset = 1'b0;
    void'(sb.pop_back());
    step();
    chk("abort_spi_clk", bus_a.spi_clk, 0);
    chk("abort_spi_latch", bus_a.spi_latch, 0);
    chk("abort_ready", bus_a.cfg_ready, 1);
    chk("abort_busy", bus_a.busy, 0);
    nreset = 1'b1;
    repeat (30) step();
    chk("abort_no_done", done_cnt_a, dc);
    chk("abort_regout_kept", regout_a, 8'h96);
    send_a(8'h5A, 1'b0);
    wait_idle_a();

`ifdef ROUTE_CFG_READBACK_EN
    send_a(8'h12, 1'b0);
    wait_idle_a();
    chk("rb_err_12", bus_a.cfg_err, 0);
    send_a(8'h34, 1'b0);
    wait_idle_a();
    chk("rb_err_34", bus_a.cfg_err, 0);
    corrupt = 1'b1;
    send_a(8'h56, 1'b1);
    n = 0;
    while (!bus_a.spi_latch && n < 200) begin
      step();
      n++;
    end
    chk("rb_err_set_at_latch", bus_a.cfg_err, 1);
    wait_idle_a();
    corrupt = 1'b0;
    send_a(8'h78, 1'b0);
    chk("rb_err_clr_on_accept", bus_a.cfg_err, 0);
    wait_idle_a();
`endif

    // Back-to-back on the CLKDIV=1 controller with cfg_valid held
    chk("b_ready_pre", bus_b.cfg_ready, 1);
    bus_b.cfg_valid = 1'b1;
    bus_b.cfg_data  = 8'hFF;
    step();
    a1 = cyc;
    bus_b.cfg_data = 8'h00;
    n = 0; hi = 0;
    while (!bus_b.done && n < 100) begin
      if (bus_b.cfg_ready) hi++;
      step();
      n++;
    end
    d1 = cyc;
    chk("b_latency1", d1 - a1, LAT_B);
    chk("b_ready_low1", hi, 0);
    chk("b_regout1", regout_b, 8'hFF);
    step();
    chk("b_ready_after_done", bus_b.cfg_ready, 1);
    step();
    a2 = cyc;
    chk("b_accept_gap", a2 - d1, 2);
    chk("b_ready_low_accept2", bus_b.cfg_ready, 0);
    bus_b.cfg_valid = 1'b0;
    n = 0; hi = 0;
    while (!bus_b.done && n < 100) begin
      if (bus_b.cfg_ready) hi++;
      step();
      n++;
    end
    d2 = cyc;
    chk("b_latency2", d2 - a2, LAT_B);
    chk("b_ready_low2", hi, 0);
    chk("b_regout2", regout_b, 8'h00);
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
